// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the calculator: turns key codes into memory strobes,
// launches the ALU, and supervises its completion with a timeout.
module calc_sequencer #(
  parameter int MAX_DIGITS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       mem_set,
  output logic       mem_clr,
  output logic [1:0] mem_loc,
  output logic [3:0] mem_data,
  output logic [1:0] mem_display,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       busy,
  output logic       error
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_ENTER_A = 3'd1,
    S_ENTER_B = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_a_q;
  logic [CW-1:0] cnt_b_q;
  logic [TW-1:0] timer_q;
  logic          key_ready_q, mem_set_q, mem_clr_q, alu_start_q, busy_q, error_q;
  logic [1:0]    mem_loc_q, mem_display_q;
  logic [3:0]    mem_data_q;

  logic key_acc_d, is_digit_d, is_op_d, is_eq_d, is_clr_d;

  assign key_acc_d  = key_valid & key_ready_q;
  assign is_digit_d = (key_code <= 4'd9);
  assign is_op_d    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq_d    = (key_code == 4'd14);
  assign is_clr_d   = (key_code == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      cnt_a_q       <= '0;
      cnt_b_q       <= '0;
      timer_q       <= '0;
      key_ready_q   <= 1'b0;
      mem_set_q     <= 1'b0;
      mem_clr_q     <= 1'b0;
      mem_loc_q     <= 2'b00;
      mem_data_q    <= 4'h0;
      mem_display_q <= 2'b00;
      alu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      mem_set_q   <= 1'b0;
      mem_clr_q   <= 1'b0;
      alu_start_q <= 1'b0;
      // F is only ever accepted in the key-ready states, so it can pre-empt the case.
      if (key_acc_d && is_clr_d) begin
        mem_clr_q   <= 1'b1;
        error_q     <= 1'b0;
        key_ready_q <= 1'b0;
        state_q     <= S_CLEAR;
      end else begin
        case (state_q)
          S_CLEAR: begin
            // Entered via F/digit the clear strobe already went out; after reset it has not.
            mem_clr_q     <= ~mem_clr_q;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            mem_display_q <= 2'b00;
            key_ready_q   <= 1'b1;
            state_q       <= S_ENTER_A;
          end
          S_ENTER_A: begin
            if (key_acc_d && is_digit_d && (cnt_a_q < CNT_MAX)) begin
              mem_set_q  <= 1'b1;
              mem_loc_q  <= 2'b00;
              mem_data_q <= key_code;
              cnt_a_q    <= cnt_a_q + CW'(1);
            end else if (key_acc_d && is_op_d && (cnt_a_q != '0)) begin
              mem_set_q     <= 1'b1;
              mem_loc_q     <= 2'b10;
              mem_data_q    <= key_code;
              mem_display_q <= 2'b01;
              state_q       <= S_ENTER_B;
            end else begin
              state_q <= S_ENTER_A;
            end
          end
          S_ENTER_B: begin
            if (key_acc_d && is_digit_d && (cnt_b_q < CNT_MAX)) begin
              mem_set_q  <= 1'b1;
              mem_loc_q  <= 2'b01;
              mem_data_q <= key_code;
              cnt_b_q    <= cnt_b_q + CW'(1);
            end else if (key_acc_d && is_op_d && (cnt_b_q == '0)) begin
              mem_set_q  <= 1'b1;
              mem_loc_q  <= 2'b10;
              mem_data_q <= key_code;
            end else if (key_acc_d && is_eq_d && (cnt_b_q != '0)) begin
              alu_start_q <= 1'b1;
              busy_q      <= 1'b1;
              timer_q     <= '0;
              key_ready_q <= 1'b0;
              state_q     <= S_EXEC;
            end else begin
              state_q <= S_ENTER_B;
            end
          end
          S_EXEC: begin
            if (alu_done) begin
              busy_q      <= 1'b0;
              key_ready_q <= 1'b1;
              if (alu_err) begin
                error_q <= 1'b1;
                state_q <= S_ERROR;
              end else begin
                mem_display_q <= 2'b10;
                state_q       <= S_SHOW;
              end
            end else if (timer_q == TMR_MAX) begin
              busy_q      <= 1'b0;
              error_q     <= 1'b1;
              key_ready_q <= 1'b1;
              state_q     <= S_ERROR;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_SHOW: begin
            if (key_acc_d && is_digit_d) begin
              mem_clr_q   <= 1'b1;
              key_ready_q <= 1'b0;
              state_q     <= S_CLEAR;
            end else begin
              state_q <= S_SHOW;
            end
          end
          S_ERROR: begin
            state_q <= S_ERROR;
          end
          default: begin
            key_ready_q <= 1'b0;
            state_q     <= S_CLEAR;
          end
        endcase
      end
    end
  end

  assign key_ready   = key_ready_q;
  assign mem_set     = mem_set_q;
  assign mem_clr     = mem_clr_q;
  assign mem_loc     = mem_loc_q;
  assign mem_data    = mem_data_q;
  assign mem_display = mem_display_q;
  assign alu_start   = alu_start_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus a randomized
// run scored against a key-by-key behavioural model of the calculator controller.
module tb_calc_sequencer;
  localparam int MAXD = 4;
  localparam int TMO  = 255;
  localparam int M_RST = 0, M_CLR = 1, M_A = 2, M_B = 3, M_EXEC = 4, M_SHOW = 5, M_ERR = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1, key_valid = 1'b0, alu_done = 1'b0, alu_err = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ready, mem_set, mem_clr, alu_start, busy, error;
  logic [1:0] mem_loc, mem_display;
  logic [3:0] mem_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] obs[$];
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic       set;
    logic       clr;
    logic       start;
    logic [1:0] loc;
    logic [3:0] data;
  } strobe_t;

  int         m_mode, m_ca, m_cb, m_tmr;
  logic [1:0] m_disp;
  logic       m_err;

  calc_sequencer #(.MAX_DIGITS(MAXD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .mem_set(mem_set), .mem_clr(mem_clr), .mem_loc(mem_loc),
    .mem_data(mem_data), .mem_display(mem_display), .alu_start(alu_start),
    .alu_done(alu_done), .alu_err(alu_err), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ev(input logic [1:0] t, input logic [1:0] l, input logic [3:0] d);
    return {t, l, d};
  endfunction

  // Event codes: type 1 = write (loc,data), 2 = clear, 3 = ALU start.
  task automatic step(input logic kv, input logic [3:0] kc, input logic done, input logic aerr);
    key_valid = kv; key_code = kc; alu_done = done; alu_err = aerr;
    @(posedge clk); #1;
    key_valid = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    if (mem_set)   obs.push_back(ev(2'd1, mem_loc, mem_data));
    if (mem_clr)   obs.push_back(ev(2'd2, 2'd0, 4'd0));
    if (alu_start) obs.push_back(ev(2'd3, 2'd0, 4'd0));
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Reference: what one clock edge does, reasoned per key from the calculator rules.
  function automatic strobe_t model_cycle(input logic kv, input logic [3:0] k,
                                          input logic done, input logic aerr);
    strobe_t s = '0;
    if (m_mode == M_RST || m_mode == M_CLR) begin
      s.clr = (m_mode == M_RST);
      m_mode = M_A; m_ca = 0; m_cb = 0; m_disp = 2'd0;
    end else if (m_mode == M_EXEC) begin
      if (done) begin
        if (aerr) begin m_err = 1'b1; m_mode = M_ERR; end
        else begin m_disp = 2'd2; m_mode = M_SHOW; end
      end else if (m_tmr == TMO) begin
        m_err = 1'b1; m_mode = M_ERR;
      end else m_tmr++;
    end else if (kv) begin
      if (k == 4'hF) begin
        s.clr = 1'b1; m_err = 1'b0; m_mode = M_CLR;
      end else if (m_mode == M_A || m_mode == M_B) begin
        if (k <= 4'd9) begin
          if (m_mode == M_A && m_ca < MAXD) begin
            s.set = 1'b1; s.loc = 2'd0; s.data = k; m_ca++;
          end else if (m_mode == M_B && m_cb < MAXD) begin
            s.set = 1'b1; s.loc = 2'd1; s.data = k; m_cb++;
          end
        end else if (k <= 4'd13) begin
          if ((m_mode == M_A && m_ca > 0) || (m_mode == M_B && m_cb == 0)) begin
            s.set = 1'b1; s.loc = 2'd2; s.data = k;
            if (m_mode == M_A) begin m_disp = 2'd1; m_mode = M_B; end
          end
        end else if (m_mode == M_B && m_cb > 0) begin
          s.start = 1'b1; m_tmr = 0; m_mode = M_EXEC;
        end
      end else if (m_mode == M_SHOW && k <= 4'd9) begin
        s.clr = 1'b1; m_mode = M_CLR;
      end
    end
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    m_mode = M_RST; m_ca = 0; m_cb = 0; m_tmr = 0; m_disp = 2'd0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_set, mem_clr, alu_start, busy, error, key_ready, mem_display} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {mem_set, mem_clr, alu_start, busy, error, key_ready, mem_display});
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (mem_clr !== 1'b1) begin failures++; $display("FAIL reset_clr_pulse: got %b want 1", mem_clr); end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({mem_clr, key_ready, mem_display} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_ready: clr/ready/disp got %b want 0100", {mem_clr, key_ready, mem_display});
    end
  endtask

  task automatic test_basic_calc();
    obs.delete();
    press(4'd1); press(4'd2); press(4'hA); press(4'd3);
    step(1'b1, 4'hE, 1'b0, 1'b0);
    checks++;
    if ({alu_start, busy} !== 2'b11) begin failures++; $display("FAIL basic_start: got %b want 11", {alu_start, busy}); end
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({alu_start, busy} !== 2'b01) begin failures++; $display("FAIL basic_busy_hold: got %b want 01", {alu_start, busy}); end
    step(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({mem_display, busy, error} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_done: disp/busy/err got %b want 1000", {mem_display, busy, error});
    end
    exp_q = '{ev(2'd1, 2'd0, 4'd1), ev(2'd1, 2'd0, 4'd2), ev(2'd1, 2'd2, 4'hA),
              ev(2'd1, 2'd1, 4'd3), ev(2'd3, 2'd0, 4'd0)};
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count: got %0d events want %0d", obs.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL basic_event%0d: got %h want %h", i, obs[i], exp_q[i]); end
      end
    end
    press(4'hF);
  endtask

  task automatic test_saturation();
    obs.delete();
    for (int d = 1; d <= 5; d++) press(4'(d));
    checks++;
    if (obs.size() != MAXD) begin
      failures++; $display("FAIL sat_count: got %0d writes want %0d", obs.size(), MAXD);
    end else begin
      checks++;
      if (obs[MAXD-1] !== ev(2'd1, 2'd0, 4'(MAXD))) begin
        failures++; $display("FAIL sat_last: got %h want %h", obs[MAXD-1], ev(2'd1, 2'd0, 4'(MAXD)));
      end
    end
    press(4'hF);
  endtask

  task automatic test_op_rewrite();
    obs.delete();
    press(4'hA); press(4'hE);
    checks++;
    if (obs.size() != 0) begin failures++; $display("FAIL op_early: got %0d events want 0", obs.size()); end
    press(4'd7); press(4'hA); press(4'hC); press(4'd2);
    exp_q = '{ev(2'd1, 2'd0, 4'd7), ev(2'd1, 2'd2, 4'hA), ev(2'd1, 2'd2, 4'hC), ev(2'd1, 2'd1, 4'd2)};
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++; $display("FAIL op_count: got %0d events want %0d", obs.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL op_event%0d: got %h want %h", i, obs[i], exp_q[i]); end
      end
    end
    press(4'hF);
  endtask

  task automatic test_timeout();
    int n;
    press(4'd1); press(4'hA); press(4'd2);
    step(1'b1, 4'hE, 1'b0, 1'b0);
    n = 0;
    while (error !== 1'b1 && n < TMO + 20) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      n++;
    end
    // Timer counts 0..TIMEOUT on successive EXEC cycles; expiry is on the last of those.
    checks++;
    if (n != TMO + 1) begin failures++; $display("FAIL timeout_latency: got %0d cycles want %0d", n, TMO + 1); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b want 0", busy); end
    obs.delete();
    press(4'd5);
    checks++;
    if (obs.size() != 0 || error !== 1'b1) begin
      failures++; $display("FAIL error_ignores_digit: events %0d err %b want 0 1", obs.size(), error);
    end
    press(4'hF);
    checks++;
    if (obs.size() != 1 || obs[0] !== ev(2'd2, 2'd0, 4'd0) || error !== 1'b0) begin
      failures++; $display("FAIL error_clear: events %0d err %b want 1 clr, err 0", obs.size(), error);
    end
  endtask

  task automatic test_reset_mid_exec();
    press(4'd1); press(4'hA); press(4'd2);
    step(1'b1, 4'hE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({mem_display, error, busy, mem_clr} !== 5'b00001) begin
      failures++; $display("FAIL midexec_reset: disp/err/busy/clr got %b want 00001", {mem_display, error, busy, mem_clr});
    end
    step(1'b0, 4'h0, 1'b1, 1'b1);
    checks++;
    if ({mem_display, error, busy, key_ready} !== 5'b00001) begin
      failures++; $display("FAIL late_done_ignored: disp/err/busy/rdy got %b want 00001", {mem_display, error, busy, key_ready});
    end
  endtask

  task automatic test_random();
    strobe_t    s;
    logic       kv, dn, ae;
    logic [3:0] k;
    int         r;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r  = $urandom_range(0, 99);
      k  = (r < 50) ? 4'($urandom_range(0, 9)) : (r < 72) ? 4'($urandom_range(10, 13)) :
           (r < 90) ? 4'hE : 4'hF;
      kv = ($urandom_range(0, 2) != 0);
      dn = ($urandom_range(0, 9) == 0);
      ae = ($urandom_range(0, 2) == 0);
      s  = model_cycle(kv, k, dn, ae);
      step(kv, k, dn, ae);
      checks++;
      if ({mem_set, mem_clr, alu_start} !== {s.set, s.clr, s.start}) begin
        failures++; $display("FAIL rand_strobe c%0d: set/clr/start got %b want %b", cyc,
                             {mem_set, mem_clr, alu_start}, {s.set, s.clr, s.start});
      end
      if (s.set) begin
        checks++;
        if ({mem_loc, mem_data} !== {s.loc, s.data}) begin
          failures++; $display("FAIL rand_write c%0d: loc/data got %h want %h", cyc, {mem_loc, mem_data}, {s.loc, s.data});
        end
      end
      checks++;
      if ({mem_display, key_ready, busy, error} !== {m_disp, (m_mode == M_A || m_mode == M_B ||
          m_mode == M_SHOW || m_mode == M_ERR), (m_mode == M_EXEC), m_err}) begin
        failures++; $display("FAIL rand_status c%0d: disp/rdy/busy/err got %b mode %0d", cyc,
                             {mem_display, key_ready, busy, error}, m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_calc();
    test_saturation();
    test_op_rewrite();
    test_timeout();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
